// File: rtl/window_checker.sv
// window_checker: after a trigger rise and a fixed delay, checks that every event channel
// fires inside a bounded window while guard stays low; reports pass/fail with statistics.
module window_checker #(
  parameter int NUM_CH       = 2,
  parameter int DELAY        = 2,
  parameter int TIMEOUT      = 16,
  parameter int OVERLAP_FAIL = 0,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              guard,
  input  logic [NUM_CH-1:0] ev,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [NUM_CH-1:0] hit_mask,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_WINDOW} state_t;
  state_t            state_q, state_d;
  logic              trig_q;
  logic [7:0]        dcnt_q, dcnt_d;
  logic [16:0]       len_q, len_d, len_n;
  logic [NUM_CH-1:0] hit_q, hit_d, hm;
  logic              pass_q, pass_d, fail_q, fail_d;
  logic [1:0]        code_q, code_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d, fcnt_q, fcnt_d;
  logic              rise, new_chk, smp, g_f, done, ovl, to;
  always_comb begin
    rise    = trig & ~trig_q;
    new_chk = state_q == S_IDLE & rise;
    // with zero delay the rise edge itself is the first window sample
    smp     = state_q == S_WINDOW | (new_chk & DELAY == 0);
    hm      = (new_chk ? '0 : hit_q) | ev;
    len_n   = (new_chk ? 17'd0 : len_q) + 17'd1;
    g_f     = smp & guard;
    done    = smp & (&hm);
    ovl     = OVERLAP_FAIL != 0 & rise & state_q != S_IDLE;
    to      = smp & len_n == 17'(TIMEOUT);
    pass_d  = done & ~g_f;
    fail_d  = g_f | (~done & (ovl | to));
    code_d  = ~fail_d ? code_q : g_f ? 2'd1 : ovl ? 2'd3 : 2'd2;
    state_d = (pass_d | fail_d) ? S_IDLE :
              new_chk ? (DELAY <= 1 ? S_WINDOW : S_DELAY) :
              (state_q == S_DELAY & dcnt_q == 8'd0) ? S_WINDOW : state_q;
    dcnt_d  = new_chk ? 8'(DELAY > 1 ? DELAY - 2 : 0) :
              state_q == S_DELAY ? dcnt_q - 8'd1 : dcnt_q;
    hit_d   = smp ? hm : new_chk ? '0 : hit_q;
    len_d   = smp ? len_n : new_chk ? 17'd0 : len_q;
    pcnt_d  = (pass_d & ~&pcnt_q) ? pcnt_q + 1'b1 : pcnt_q;
    fcnt_d  = (fail_d & ~&fcnt_q) ? fcnt_q + 1'b1 : fcnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
      dcnt_q  <= '0;
      len_q   <= '0;
      hit_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= '0;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig;
      dcnt_q  <= dcnt_d;
      len_q   <= len_d;
      hit_q   <= hit_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
      pcnt_q  <= pcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end
  assign busy      = state_q != S_IDLE;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = code_q;
  assign hit_mask  = hit_q;
  assign pass_cnt  = pcnt_q;
  assign fail_cnt  = fcnt_q;
endmodule

// File: tb/tb_window_checker.sv
// tb_window_checker: directed vectors on three configurations (overlap ignored,
// overlap failing, zero delay with narrow counters) against hand-computed results.
module tb_window_checker;
  logic clk = 1'b0, rst = 1'b0, trig = 1'b0, guard = 1'b0;
  logic [1:0] ev = '0;
  int checks = 0, errors = 0;
  logic busy_a, pass_a, fail_a, busy_b, pass_b, fail_b, busy_c, pass_c, fail_c;
  logic [1:0] code_a, code_b, code_c, hit_a, hit_b, hit_c;
  logic [15:0] pcnt_a, fcnt_a, pcnt_b, fcnt_b;
  logic [2:0] pcnt_c, fcnt_c;
  always #5 clk = ~clk;
  window_checker #(.NUM_CH(2), .DELAY(2), .TIMEOUT(8), .OVERLAP_FAIL(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .trig(trig), .guard(guard), .ev(ev), .busy(busy_a), .pass(pass_a),
    .fail(fail_a), .fail_code(code_a), .hit_mask(hit_a), .pass_cnt(pcnt_a), .fail_cnt(fcnt_a));
  window_checker #(.NUM_CH(2), .DELAY(2), .TIMEOUT(8), .OVERLAP_FAIL(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .trig(trig), .guard(guard), .ev(ev), .busy(busy_b), .pass(pass_b),
    .fail(fail_b), .fail_code(code_b), .hit_mask(hit_b), .pass_cnt(pcnt_b), .fail_cnt(fcnt_b));
  window_checker #(.NUM_CH(2), .DELAY(0), .TIMEOUT(8), .OVERLAP_FAIL(0), .CNT_W(3)) dut_c (
    .clk(clk), .rst(rst), .trig(trig), .guard(guard), .ev(ev), .busy(busy_c), .pass(pass_c),
    .fail(fail_c), .fail_code(code_c), .hit_mask(hit_c), .pass_cnt(pcnt_c), .fail_cnt(fcnt_c));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic t, input logic g, input logic [1:0] e);
    trig = t;
    guard = g;
    ev = e;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    tick(0, 0, 0);
    tick(0, 0, 0);
    rst = 1'b0;
    chk("rst_busy", busy_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_fail", fail_a, 0);
    chk("rst_code", code_a, 0);
    chk("rst_hit", hit_a, 0);
    chk("rst_cnts", {pcnt_a, fcnt_a}, 0);
    // basic pass: rise E1, ev0 E4, ev1 E6
    tick(0, 0, 0);
    tick(1, 0, 0);
    chk("p_busy_e1", busy_a, 1);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 2'b01);
    chk("p_hit_e4", hit_a, 2'b01);
    tick(0, 0, 0);
    chk("p_nopass_e5", pass_a, 0);
    chk("p_busy_e5", busy_a, 1);
    tick(0, 0, 2'b10);
    chk("p_pass", pass_a, 1);
    chk("p_busy_done", busy_a, 0);
    chk("p_fail", fail_a, 0);
    chk("p_cnt", pcnt_a, 1);
    chk("p_hit", hit_a, 2'b11);
    tick(0, 0, 0);
    chk("p_pulse_end", pass_a, 0);
    // guard at E5
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 2'b01);
    tick(0, 1, 0);
    chk("g_fail", fail_a, 1);
    chk("g_code", code_a, 1);
    chk("g_hit", hit_a, 2'b01);
    chk("g_fcnt", fcnt_a, 1);
    tick(0, 0, 2'b10);
    chk("g_nopass", pass_a, 0);
    chk("g_hit_held", hit_a, 2'b01);
    chk("g_code_held", code_a, 1);
    // timeout: ev1 at E2 lies before the window
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 2'b10);
    tick(0, 0, 2'b01);
    for (int i = 4; i <= 9; i++) tick(0, 0, 0);
    chk("t_nofail_e9", fail_a, 0);
    chk("t_busy_e9", busy_a, 1);
    tick(0, 0, 0);
    chk("t_fail", fail_a, 1);
    chk("t_code", code_a, 2);
    chk("t_hit", hit_a, 2'b01);
    chk("t_fcnt", fcnt_a, 2);
    // overlap: rise E1, fall E2, rise E4
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    chk("o1_fail", fail_b, 1);
    chk("o1_code", code_b, 3);
    chk("o0_nofail", fail_a, 0);
    chk("o0_busy", busy_a, 1);
    tick(0, 0, 0);
    chk("o1_idle", busy_b, 0);
    for (int i = 6; i <= 9; i++) tick(0, 0, 0);
    tick(0, 0, 0);
    chk("o0_fail", fail_a, 1);
    chk("o0_code", code_a, 2);
    chk("o1_fcnt", fcnt_b, 3);
    chk("o1_quiet", fail_b, 0);
    // guard and final event on the same edge
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 2'b01);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 2'b10);
    chk("gc_fail", fail_a, 1);
    chk("gc_pass", pass_a, 0);
    chk("gc_code", code_a, 1);
    chk("gc_fcnt", fcnt_a, 4);
    // reset mid-check, then a fresh check
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 2'b01);
    rst = 1'b1;
    tick(0, 0, 0);
    rst = 1'b0;
    chk("r_outs", {busy_a, pass_a, fail_a, code_a, hit_a}, 0);
    chk("r_cnts", {pcnt_a, fcnt_a}, 0);
    tick(0, 0, 0);
    chk("r_nopulse", {pass_a, fail_a}, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 2'b11);
    chk("r_pass", pass_a, 1);
    chk("r_pcnt", pcnt_a, 1);
    tick(1, 0, 0);
    chk("r_newchk_hit", hit_a, 0);
    chk("r_newchk_busy", busy_a, 1);
    chk("r_newchk_pass", pass_a, 0);
    // zero delay with trig already high through reset
    rst = 1'b1;
    tick(1, 0, 0);
    rst = 1'b0;
    tick(1, 0, 2'b11);
    chk("z_pass", pass_c, 1);
    chk("z_busy", busy_c, 0);
    chk("z_cnt1", pcnt_c, 1);
    for (int i = 2; i <= 11; i++) begin
      tick(0, 0, 0);
      tick(1, 0, 2'b11);
      if (i == 5) chk("z_cnt5", pcnt_c, 5);
    end
    chk("z_pass_last", pass_c, 1);
    chk("z_sat", pcnt_c, 3'b111);
    chk("z_fcnt", fcnt_c, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
